// File: rtl/multi_channel_clock_divider.sv
// Multi-channel programmable clock divider: NUM_CH modulo counters with per-channel
// tick, square wave and a shadowed divisor that only takes effect at a wrap or clear.
module multi_channel_clock_divider #(
  parameter int NBITS       = 16,
  parameter int NUM_CH      = 2,
  parameter int DEFAULT_DIV = 5,
  parameter int CH_BITS     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       enable,
  input  logic                    sync_clear,
  input  logic                    load_valid,
  input  logic [CH_BITS-1:0]      load_ch,
  input  logic [NBITS-1:0]        load_div,
  output logic                    load_ready,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       square,
  output logic [NUM_CH*NBITS-1:0] count_out,
  output logic [NUM_CH*NBITS-1:0] div_out
);

  localparam logic [NBITS-1:0] ONE       = NBITS'(1);
  localparam logic [NBITS-1:0] RESET_DIV = (DEFAULT_DIV <= 1) ? NBITS'(1) : NBITS'(DEFAULT_DIV);

  logic [NUM_CH-1:0] pend_valid_vec;
  logic [NUM_CH-1:0] write_sel;
  logic              load_accept;

  // Out-of-range channels are always ready so their writes drain and are dropped.
  always_comb begin
    load_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (load_ch == CH_BITS'(i)) begin
        load_ready = ~pend_valid_vec[i];
      end
    end
  end

  assign load_accept = load_valid & load_ready;

  always_comb begin
    write_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      write_sel[i] = load_accept & (load_ch == CH_BITS'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [NBITS-1:0] count_q, count_d;
    logic [NBITS-1:0] div_q, div_d;
    logic [NBITS-1:0] pend_q, pend_d;
    logic             square_q, square_d;
    logic             pend_valid_q, pend_valid_d;
    logic [NBITS-1:0] last_cnt;
    logic             wrap;
    logic             apply;

    // A stored divisor of 0 behaves like 1, so both give a terminal count of 0.
    always_comb begin
      last_cnt = (div_q == '0) ? '0 : div_q - ONE;
      wrap     = enable[g] & (count_q == last_cnt);
    end

    assign tick[g] = wrap & ~sync_clear & ~reset;

    always_comb begin
      count_d      = count_q;
      square_d     = square_q;
      div_d        = div_q;
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
      apply        = pend_valid_q & (sync_clear | wrap);

      if (sync_clear) begin
        count_d  = '0;
        square_d = 1'b0;
      end else if (wrap) begin
        count_d  = '0;
        square_d = ~square_q;
      end else if (enable[g]) begin
        count_d = count_q + ONE;
      end

      if (apply) begin
        div_d        = pend_q;
        pend_valid_d = 1'b0;
      end

      // A write is only accepted when nothing is pending, so it never collides with apply.
      if (write_sel[g]) begin
        pend_d       = load_div;
        pend_valid_d = 1'b1;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        count_q      <= '0;
        square_q     <= 1'b0;
        div_q        <= RESET_DIV;
        pend_q       <= '0;
        pend_valid_q <= 1'b0;
      end else begin
        count_q      <= count_d;
        square_q     <= square_d;
        div_q        <= div_d;
        pend_q       <= pend_d;
        pend_valid_q <= pend_valid_d;
      end
    end

    assign pend_valid_vec[g]             = pend_valid_q;
    assign square[g]                     = square_q;
    assign count_out[g*NBITS +: NBITS]   = count_q;
    assign div_out[g*NBITS +: NBITS]     = div_q;
  end

endmodule

// File: tb/tb_multi_channel_clock_divider.sv
// Directed plus randomized bench for multi_channel_clock_divider, compared against
// a per-channel arithmetic model of periods, phases and shadowed divisors.
module tb_multi_channel_clock_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  enable;
  logic        sync_clear;
  logic        load_valid;
  logic [0:0]  load_ch;
  logic [15:0] load_div;
  logic        load_ready;
  logic [1:0]  tick;
  logic [1:0]  square;
  logic [31:0] count_out;
  logic [31:0] div_out;

  int checks = 0;
  int errors = 0;

  int m_cnt[2];
  int m_sq[2];
  int m_div[2];
  int m_pend[2];
  int m_pv[2];

  multi_channel_clock_divider #(
    .NBITS(16), .NUM_CH(2), .DEFAULT_DIV(5), .CH_BITS(1)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .sync_clear(sync_clear),
    .load_valid(load_valid), .load_ch(load_ch), .load_div(load_div),
    .load_ready(load_ready), .tick(tick), .square(square),
    .count_out(count_out), .div_out(div_out)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int deff(input int c);
    return (m_div[c] == 0) ? 1 : m_div[c];
  endfunction

  function automatic logic m_tick(input int c);
    return !reset && enable[c] && !sync_clear && (m_cnt[c] == deff(c) - 1);
  endfunction

  function automatic logic m_ready();
    return m_pv[int'(load_ch)] == 0;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_cnt[c] = 0;
      m_sq[c]  = 0;
      m_div[c] = 5;
      m_pv[c]  = 0;
    end
  endtask

  // One clock edge of the reference: advance phase modulo Deff, swap in the shadow at a boundary.
  task automatic model_edge();
    logic acc;
    logic boundary;
    if (reset) begin
      model_reset();
      return;
    end
    acc = load_valid && m_ready();
    for (int c = 0; c < 2; c++) begin
      boundary = sync_clear || (enable[c] && m_cnt[c] == deff(c) - 1);
      if (sync_clear) begin
        m_cnt[c] = 0;
        m_sq[c]  = 0;
      end else if (enable[c]) begin
        m_cnt[c] = (m_cnt[c] + 1) % deff(c);
        if (m_cnt[c] == 0) m_sq[c] = 1 - m_sq[c];
      end
      if (boundary && m_pv[c] != 0) begin
        m_div[c] = m_pend[c];
        m_pv[c]  = 0;
      end
      if (acc && int'(load_ch) == c) begin
        m_pend[c] = int'(load_div);
        m_pv[c]   = 1;
      end
    end
  endtask

  task automatic compare_all();
    logic [1:0]  e_tick;
    logic [1:0]  e_sq;
    logic [31:0] e_cnt;
    logic [31:0] e_div;
    e_tick = {m_tick(1), m_tick(0)};
    e_sq   = {m_sq[1] != 0, m_sq[0] != 0};
    e_cnt  = {16'(m_cnt[1]), 16'(m_cnt[0])};
    e_div  = {16'(m_div[1]), 16'(m_div[0])};
    check_output("tick", 32'(tick), 32'(e_tick));
    check_output("square", 32'(square), 32'(e_sq));
    check_output("count_out", count_out, e_cnt);
    check_output("div_out", div_out, e_div);
    check_output("load_ready", 32'(load_ready), 32'(m_ready()));
  endtask

  // Inputs are held from just after one rising edge until just after the next.
  task automatic apply_stimulus();
    @(negedge clk);
    if (reset) model_reset();
    compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run_until(input int c, input int val, input string tag);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (m_cnt[c] == val) found = 1'b1;
      else apply_stimulus();
    end
    check_output(tag, 32'(found), 32'd1);
  endtask

  task automatic write_div(input logic [0:0] ch, input logic [15:0] d);
    load_valid = 1'b1;
    load_ch    = ch;
    load_div   = d;
    apply_stimulus();
    load_valid = 1'b0;
  endtask

  initial begin
    int seq[6];
    seq = '{0, 1, 2, 3, 4, 0};
    reset = 1'b1;
    enable = 2'b00;
    sync_clear = 1'b0;
    load_valid = 1'b0;
    load_ch = 1'b0;
    load_div = '0;
    model_reset();
    for (int c = 0; c < 2; c++) m_pend[c] = 0;
    repeat (3) apply_stimulus();
    check_output("reset_div", div_out, 32'h0005_0005);
    check_output("reset_ready", 32'(load_ready), 32'd1);
    check_output("reset_count", count_out, 32'd0);

    // Default divisor, both channels free-running.
    reset = 1'b0;
    enable = 2'b11;
    for (int k = 0; k < 6; k++) begin
      check_output("seq_ch0", 32'(count_out[15:0]), 32'(seq[k]));
      apply_stimulus();
    end
    repeat (10) apply_stimulus();

    // Reprogram ch0 to 3 mid-period; a second write must be blocked while pending.
    run_until(0, 1, "wait_ch0_cnt1");
    write_div(1'b0, 16'd3);
    check_output("ready_blocked", 32'(load_ready), 32'd0);
    write_div(1'b0, 16'd9);
    repeat (12) apply_stimulus();
    check_output("ch0_div3", 32'(div_out[15:0]), 32'd3);

    // Divisors 0 and 1 both collapse to a single-cycle period.
    write_div(1'b0, 16'd0);
    repeat (8) apply_stimulus();
    write_div(1'b0, 16'd1);
    repeat (6) apply_stimulus();
    check_output("deff1_count", 32'(count_out[15:0]), 32'd0);
    check_output("deff1_tick", 32'(tick[0]), 32'd1);
    write_div(1'b0, 16'd4);
    repeat (6) apply_stimulus();

    // Stall ch1 for four cycles mid-period.
    run_until(1, 2, "wait_ch1_cnt2");
    enable = 2'b01;
    repeat (4) apply_stimulus();
    check_output("ch1_hold", 32'(count_out[31:16]), 32'd2);
    enable = 2'b11;
    repeat (8) apply_stimulus();

    // Phase-align with a pending divisor on ch1.
    write_div(1'b1, 16'd7);
    repeat (2) apply_stimulus();
    sync_clear = 1'b1;
    apply_stimulus();
    sync_clear = 1'b0;
    check_output("clear_count", count_out, 32'd0);
    check_output("clear_square", 32'(square), 32'd0);
    check_output("clear_div_ch1", 32'(div_out[31:16]), 32'd7);
    repeat (10) apply_stimulus();

    // Reset with ch0 pending: shadow is lost, defaults return.
    write_div(1'b0, 16'd9);
    reset = 1'b1;
    apply_stimulus();
    check_output("midreset_div", div_out, 32'h0005_0005);
    check_output("midreset_ready", 32'(load_ready), 32'd1);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check_output("first_tick", 32'(tick[0]), (k == 4) ? 32'd1 : 32'd0);
      apply_stimulus();
    end

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      enable     = 2'($urandom);
      sync_clear = ($urandom_range(0, 19) == 0);
      load_valid = ($urandom_range(0, 2) == 0);
      load_ch    = 1'($urandom);
      load_div   = 16'($urandom_range(0, 6));
      reset      = ($urandom_range(0, 99) == 0);
      apply_stimulus();
    end
    reset = 1'b0;
    apply_stimulus();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_channel_clock_divider.md
Name: multi_channel_clock_divider

Overview:
- Parametrised successor to the fixed-modulus clock divider: NUM_CH independent modulo counters, each with its own divisor that can be reprogrammed at runtime.
- Each channel produces a one-cycle tick, a 50%-duty square wave and its current count.
- Divisor writes go through a valid/ready load port into a per-channel shadow register, which takes effect only at the channel's wrap point, so no period is ever glitched.
- Sits in the timing/clock-enable generation layer and feeds tick-driven peripherals such as UART baud, PWM and scan timers.

Parameters:
- NBITS, 16, width of each counter and divisor.
- NUM_CH, 2, number of channels (>=1).
- DEFAULT_DIV, 5, divisor loaded into every channel at reset. Values 0 and 1 are both treated as 1.
- CH_BITS, max(1, CeilLog2(NUM_CH)), width of the channel select.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  NUM_CH  per-channel count enable.
- sync_clear  in  1  synchronous phase-align of all channels.
- load_valid  in  1  divisor write request.
- load_ch  in  CH_BITS  target channel of the write.
- load_div  in  NBITS  new divisor D for the target channel.
- load_ready  out  1  write can be accepted this cycle.
- tick  out  NUM_CH  one-cycle pulse per period.
- square  out  NUM_CH  divided square wave, period 2*D enabled cycles.
- count_out  out  NUM_CH*NBITS  channel i count in bits [i*NBITS +: NBITS].
- div_out  out  NUM_CH*NBITS  active divisor of each channel, same packing.

Behaviour:
- Reset (async, reset=1) puts every channel in this state:
  - count = 0.
  - square = 0.
  - active div = max(DEFAULT_DIV, 1).
  - pending_valid = 0.
- Outputs during reset:
  - tick = 0.
  - load_ready = 1.
- Effective divisor Deff = max(active div, 1). The count runs 0 .. Deff-1.
- Per-channel, per-edge priority:
  1. sync_clear=1:
     - count <= 0, square <= 0.
     - If pending_valid, active div <= pending and pending_valid <= 0.
     - enable is ignored.
  2. enable[i]=1 and count == Deff-1 (wrap):
     - count <= 0, square <= ~square.
     - If pending_valid, active div <= pending and pending_valid <= 0.
  3. enable[i]=1 otherwise: count <= count+1.
  4. enable[i]=0: everything holds.
- tick[i] = enable[i] & ~sync_clear & (count == Deff-1).
  - Combinational from registered state plus inputs, no added latency.
  - With Deff=1, tick is high on every enabled cycle and square toggles on every enabled cycle.
- Because a divisor is applied only at wrap or clear, the count is never >= Deff. No out-of-range compare logic is required.
- load_ready = ~pending_valid[load_ch] when load_ch < NUM_CH; load_ready = 1 when load_ch >= NUM_CH.
- Write acceptance:
  - A write is accepted when load_valid & load_ready.
  - Accepted: pending[load_ch] <= load_div, pending_valid[load_ch] <= 1.
  - load_ch >= NUM_CH: the write is accepted and discarded, with no state change.
- Write on the same edge as a wrap of that channel: pending_valid was 0 (ready required), so nothing is applied on that edge. The new value is stored as pending and applied at the next wrap or clear.
- Write on the same edge as sync_clear: the value becomes pending and is applied at the next wrap or clear, not at this clear.
- Writes to other channels never affect a channel's count or phase.
- A second write to a channel that already holds a pending value is blocked (load_ready=0) until the first is applied.
- div_out reflects the active divisor, never the pending one.
- Reset mid-operation:
  - Immediate return to reset state.
  - Pending writes are lost.
  - Active div reverts to DEFAULT_DIV.
- Counter arithmetic is modulo 2^NBITS, but wrap by compare always occurs first. D = 2^NBITS-1 is the maximum period.

Test Plan:
- Reset, DEFAULT_DIV=5, enable=2'b11 held -> each tick pulses every 5 cycles; count_out sequence 0,1,2,3,4,0; square period 10 cycles; div_out=5 on both channels.
- Write load_ch=0, load_div=3 while ch0 count=1 -> load_ready drops to 0 for ch0. Ch0 completes 2,3,4, then runs a 3-cycle period from the wrap; div_out[ch0] changes on the wrap edge; ch1 is unaffected.
- load_div=0, then separately load_div=1 -> Deff=1: tick high every enabled cycle, count stays 0, square toggles every cycle.
- Toggle enable[1] low for 4 cycles mid-period with D=5 -> ch1 count, square and tick hold; the period stretches by exactly 4 cycles.
- sync_clear pulse while ch0 count=2 and ch1 count=4, with a pending value of 7 on ch1 -> both counts 0, both squares 0, tick suppressed; ch1 div_out=7 on the next cycle and pending is cleared.
- Assert reset with ch0 pending=9 at count=3 -> all outputs return to reset values, div_out=5, load_ready=1. After release, the first tick occurs 5 enabled cycles later.
